// File: rtl/fp_adder_seq.sv
// Multi-cycle sign-magnitude floating-point adder with a start/ready handshake.
// Alignment and normalisation advance one bit per cycle; the result is held until the next operation.
module fp_adder_seq #(
   parameter int EXP_W  = 4,
   parameter int FRAC_W = 8,
   parameter int GUARD  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              sign1,
   input  logic              sign2,
   input  logic [EXP_W-1:0]  exp1,
   input  logic [EXP_W-1:0]  exp2,
   input  logic [FRAC_W-1:0] frac1,
   input  logic [FRAC_W-1:0] frac2,
   output logic              ready,
   output logic              done,
   output logic              sign_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic [FRAC_W-1:0] frac_out,
   output logic              ovf,
   output logic              unf
);
   localparam int SW = FRAC_W + GUARD;
   localparam int AW = $clog2(SW + 1);
   localparam int CW = (AW > EXP_W) ? AW : EXP_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SORT  = 3'd1,
      ALIGN = 3'd2,
      ADD   = 3'd3,
      NORM  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                s1_q, s1_d, s2_q, s2_d;
   logic [EXP_W-1:0]    e1_q, e1_d, e2_q, e2_d;
   logic [FRAC_W-1:0]   f1_q, f1_d, f2_q, f2_d;
   logic                sgn_q, sgn_d;
   logic [EXP_W-1:0]    exp_q, exp_d;
   logic [SW-1:0]       big_q, big_d, small_q, small_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SW:0]         sum_q, sum_d;
   logic                sign_out_q, sign_out_d;
   logic [EXP_W-1:0]    exp_out_q, exp_out_d;
   logic [FRAC_W-1:0]   frac_out_q, frac_out_d;
   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic                done_q, done_d, ready_q, ready_d;

   logic                op1_big_s;
   logic [EXP_W-1:0]    diff_s;
   logic [CW-1:0]       diff_ext_s, amt_s;

   // Operand ordering and capped alignment distance, used in SORT.
   always_comb begin
      op1_big_s  = ({e1_q, f1_q} >= {e2_q, f2_q});
      diff_s     = op1_big_s ? (e1_q - e2_q) : (e2_q - e1_q);
      diff_ext_s = CW'(diff_s);
      if (diff_ext_s > CW'(SW)) begin
         amt_s = CW'(SW);
      end else begin
         amt_s = diff_ext_s;
      end
   end

   // Next-state and datapath update for the whole operation sequence.
   always_comb begin
      state_d    = state_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      e1_d       = e1_q;
      e2_d       = e2_q;
      f1_d       = f1_q;
      f2_d       = f2_q;
      sgn_d      = sgn_q;
      exp_d      = exp_q;
      big_d      = big_q;
      small_d    = small_q;
      cnt_d      = cnt_q;
      sum_d      = sum_q;
      sign_out_d = sign_out_q;
      exp_out_d  = exp_out_q;
      frac_out_d = frac_out_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               s1_d    = sign1;
               s2_d    = sign2;
               e1_d    = exp1;
               e2_d    = exp2;
               f1_d    = frac1;
               f2_d    = frac2;
               state_d = SORT;
            end else begin
               state_d = IDLE;
            end
         end
         SORT: begin
            if (op1_big_s) begin
               sgn_d   = s1_q;
               exp_d   = e1_q;
               big_d   = {f1_q, {GUARD{1'b0}}};
               small_d = {f2_q, {GUARD{1'b0}}};
            end else begin
               sgn_d   = s2_q;
               exp_d   = e2_q;
               big_d   = {f2_q, {GUARD{1'b0}}};
               small_d = {f1_q, {GUARD{1'b0}}};
            end
            cnt_d = amt_s;
            if (amt_s != {CW{1'b0}}) begin
               state_d = ALIGN;
            end else begin
               state_d = ADD;
            end
         end
         ALIGN: begin
            small_d = small_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ADD;
            end else begin
               state_d = ALIGN;
            end
         end
         ADD: begin
            if (s1_q == s2_q) begin
               sum_d = {1'b0, big_q} + {1'b0, small_q};
            end else begin
               sum_d = {1'b0, big_q} - {1'b0, small_q};
            end
            state_d = NORM;
         end
         NORM: begin
            // Result registers load on entry to DONE so they are valid while done is high.
            if (sum_q == {(SW+1){1'b0}}) begin
               sign_out_d = 1'b0;
               exp_out_d  = {EXP_W{1'b0}};
               frac_out_d = {FRAC_W{1'b0}};
               ovf_d      = 1'b0;
               unf_d      = 1'b0;
               state_d    = DONE;
            end else if (sum_q[SW] && (exp_q == {EXP_W{1'b1}})) begin
               sign_out_d = sgn_q;
               exp_out_d  = {EXP_W{1'b1}};
               frac_out_d = {FRAC_W{1'b1}};
               ovf_d      = 1'b1;
               unf_d      = 1'b0;
               state_d    = DONE;
            end else if (sum_q[SW]) begin
               sign_out_d = sgn_q;
               exp_out_d  = exp_q + EXP_W'(1);
               frac_out_d = sum_q[SW:GUARD+1];
               ovf_d      = 1'b0;
               unf_d      = 1'b0;
               state_d    = DONE;
            end else if (sum_q[SW-1]) begin
               sign_out_d = sgn_q;
               exp_out_d  = exp_q;
               frac_out_d = sum_q[SW-1:GUARD];
               ovf_d      = 1'b0;
               unf_d      = 1'b0;
               state_d    = DONE;
            end else if (exp_q == {EXP_W{1'b0}}) begin
               sign_out_d = 1'b0;
               exp_out_d  = {EXP_W{1'b0}};
               frac_out_d = {FRAC_W{1'b0}};
               ovf_d      = 1'b0;
               unf_d      = 1'b1;
               state_d    = DONE;
            end else begin
               sum_d   = sum_q << 1;
               exp_d   = exp_q - EXP_W'(1);
               state_d = NORM;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         e1_q       <= {EXP_W{1'b0}};
         e2_q       <= {EXP_W{1'b0}};
         f1_q       <= {FRAC_W{1'b0}};
         f2_q       <= {FRAC_W{1'b0}};
         sgn_q      <= 1'b0;
         exp_q      <= {EXP_W{1'b0}};
         big_q      <= {SW{1'b0}};
         small_q    <= {SW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         sum_q      <= {(SW+1){1'b0}};
         sign_out_q <= 1'b0;
         exp_out_q  <= {EXP_W{1'b0}};
         frac_out_q <= {FRAC_W{1'b0}};
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         e1_q       <= e1_d;
         e2_q       <= e2_d;
         f1_q       <= f1_d;
         f2_q       <= f2_d;
         sgn_q      <= sgn_d;
         exp_q      <= exp_d;
         big_q      <= big_d;
         small_q    <= small_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         sign_out_q <= sign_out_d;
         exp_out_q  <= exp_out_d;
         frac_out_q <= frac_out_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign sign_out = sign_out_q;
   assign exp_out  = exp_out_q;
   assign frac_out = frac_out_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;
endmodule
